// File: rtl/uranus_sim_pkg.sv
// ----------------------------------------------------------------------------
// uranus_sim_pkg
//   Constants and small helper functions for the simulation memory model:
//   - stall LFSR width, tap positions and default seed
//   - upper bound on read latency and a clamp helper
//   - LFSR step and ready-derivation functions
// ----------------------------------------------------------------------------
package uranus_sim_pkg;

    localparam int LFSR_WIDTH = 16;

    // Fibonacci taps 16,14,13,11 expressed as zero-based bit positions
    localparam int LFSR_TAP_A = 15;
    localparam int LFSR_TAP_B = 13;
    localparam int LFSR_TAP_C = 12;
    localparam int LFSR_TAP_D = 10;

    localparam logic [LFSR_WIDTH-1:0] DEFAULT_STALL_SEED = 16'hACE1;

    localparam int MAX_READ_LATENCY = 4;

    // One step of the stall LFSR: shift left, feedback enters at bit 0
    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] cur);
        logic fb;
        fb = cur[LFSR_TAP_A] ^ cur[LFSR_TAP_B] ^ cur[LFSR_TAP_C] ^ cur[LFSR_TAP_D];
        return {cur[LFSR_WIDTH-2:0], fb};
    endfunction

    // Two low bits OR-ed give roughly a 75% ready duty cycle
    function automatic logic lfsr_ready(input logic [LFSR_WIDTH-1:0] cur);
        return cur[0] | cur[1];
    endfunction

    // Keep the pipe depth inside the supported 1..MAX_READ_LATENCY window
    function automatic int clamp_latency(input int lat);
        if (lat < 1) begin
            return 1;
        end else if (lat > MAX_READ_LATENCY) begin
            return MAX_READ_LATENCY;
        end else begin
            return lat;
        end
    endfunction

endpackage

// File: rtl/sim_mem_rd_pipe.sv
// ----------------------------------------------------------------------------
// sim_mem_rd_pipe
//   LATENCY-deep valid + data shift register carrying read responses from the
//   accepting edge to the response port. Data stages only load when their
//   input is valid, so out_data holds the last response between pulses.
// Ports
//   clk       in   clock
//   rst       in   asynchronous active-low reset; clears valid and data
//   in_valid  in   read accepted this edge
//   in_data   in   word sampled at the accepting edge
//   out_valid out  one-cycle response pulse, LATENCY cycles after accept
//   out_data  out  response word (held while out_valid is low)
// ----------------------------------------------------------------------------
module sim_mem_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [LATENCY-1:0]    valid_r;
    logic [DATA_WIDTH-1:0] data_r [LATENCY];

    // Shift responses one stage per cycle; reset discards anything in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= {LATENCY{1'b0}};
            for (int k = 0; k < LATENCY; k++) begin
                data_r[k] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            valid_r[0] <= in_valid;
            if (in_valid) begin
                data_r[0] <= in_data;
            end
            for (int k = 1; k < LATENCY; k++) begin
                valid_r[k] <= valid_r[k-1];
                if (valid_r[k-1]) begin
                    data_r[k] <= data_r[k-1];
                end
            end
        end
    end

    assign out_valid = valid_r[LATENCY-1];
    assign out_data  = data_r[LATENCY-1];

endmodule

// File: rtl/sim_mem_model.sv
// ----------------------------------------------------------------------------
// sim_mem_model
//   Dual-port simulation memory for CPU benches. One shared word array:
//   instruction port is read-only, data port does byte-masked reads/writes.
//   Both ports have a fixed read latency, valid/ready handshake and range
//   checking with a sticky error flag.
//   Optional feature macro: SIM_MEM_STALL_EN -- per-port LFSR stall injection
//   on inst_ready / data_ready. Without it both ready outputs are 1 after reset.
// Ports
//   clk            in   clock, all updates on rising edge
//   rst            in   asynchronous active-low reset (array contents kept)
//   inst_en        in   instruction read request
//   inst_addr      in   instruction byte address
//   inst_ready     out  request accepted when inst_en && inst_ready
//   inst_rdata     out  instruction read data, valid while inst_rvalid
//   inst_rvalid    out  one pulse per accepted instruction read
//   data_en        in   data request
//   data_write_sel in   byte write enables, all-zero means read
//   data_addr      in   data byte address
//   data_wdata     in   write data, lane i = bits [8i+7:8i]
//   data_ready     out  request accepted when data_en && data_ready
//   data_rdata     out  data read data, valid while data_rvalid
//   data_rvalid    out  one pulse per accepted data read (none for writes)
//   addr_err       out  sticky flag: some accepted access was out of range
// ----------------------------------------------------------------------------
module sim_mem_model
    import uranus_sim_pkg::*;
#(
    parameter int                      ADDR_WIDTH   = 32,
    parameter int                      DATA_WIDTH   = 32,
    parameter int                      DEPTH_LOG2   = 16,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR    = {ADDR_WIDTH{1'b0}},
    parameter int                      READ_LATENCY = 1,
    parameter string                   INIT_FILE    = "",
    parameter logic [LFSR_WIDTH-1:0]   STALL_SEED   = DEFAULT_STALL_SEED
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inst_en,
    input  logic [ADDR_WIDTH-1:0]   inst_addr,
    output logic                    inst_ready,
    output logic [DATA_WIDTH-1:0]   inst_rdata,
    output logic                    inst_rvalid,
    input  logic                    data_en,
    input  logic [DATA_WIDTH/8-1:0] data_write_sel,
    input  logic [ADDR_WIDTH-1:0]   data_addr,
    input  logic [DATA_WIDTH-1:0]   data_wdata,
    output logic                    data_ready,
    output logic [DATA_WIDTH-1:0]   data_rdata,
    output logic                    data_rvalid,
    output logic                    addr_err
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int BYTE_BITS = $clog2(BYTES);
    localparam int WORDS     = 1 << DEPTH_LOG2;
    localparam int SPAN_BITS = DEPTH_LOG2 + BYTE_BITS;
    // One bit wider than both the address and the window size, so
    // BASE_ADDR + window never wraps back into the address space.
    localparam int CW        = ((ADDR_WIDTH > SPAN_BITS) ? ADDR_WIDTH : SPAN_BITS) + 1;
    localparam int LAT       = clamp_latency(READ_LATENCY);

    localparam logic [CW-1:0] LO_BOUND = CW'(BASE_ADDR);
    localparam logic [CW-1:0] HI_BOUND = CW'(BASE_ADDR) + (CW'(BYTES) << DEPTH_LOG2);

    // In range iff BASE_ADDR <= addr < BASE_ADDR + window, evaluated unwrapped
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [CW-1:0] wide;
        wide = CW'(addr);
        return (wide >= LO_BOUND) && (wide < HI_BOUND);
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [WORDS] = '{default: {DATA_WIDTH{1'b0}}};

    logic                  inst_ready_r;
    logic                  data_ready_r;
    logic                  addr_err_r;

    logic                  inst_acc_s;
    logic                  inst_ok_s;
    logic [ADDR_WIDTH-1:0] inst_off_s;
    logic [DEPTH_LOG2-1:0] inst_idx_s;
    logic [DATA_WIDTH-1:0] inst_word_s;

    logic                  data_acc_s;
    logic                  data_ok_s;
    logic                  data_is_wr_s;
    logic                  data_rd_s;
    logic                  data_wr_s;
    logic [ADDR_WIDTH-1:0] data_off_s;
    logic [DEPTH_LOG2-1:0] data_idx_s;
    logic [DATA_WIDTH-1:0] data_word_s;

    // Only the word-index bits of the offsets are consumed
    logic                  unused_addr_s;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign inst_acc_s   = inst_en & inst_ready_r;
    assign inst_ok_s    = in_range(inst_addr);
    assign inst_off_s   = inst_addr - BASE_ADDR;
    assign inst_idx_s   = inst_off_s[BYTE_BITS +: DEPTH_LOG2];

    assign data_acc_s   = data_en & data_ready_r;
    assign data_ok_s    = in_range(data_addr);
    assign data_is_wr_s = |data_write_sel;
    assign data_rd_s    = data_acc_s & ~data_is_wr_s;
    assign data_wr_s    = data_acc_s & data_is_wr_s;
    assign data_off_s   = data_addr - BASE_ADDR;
    assign data_idx_s   = data_off_s[BYTE_BITS +: DEPTH_LOG2];

    assign unused_addr_s = ^{inst_off_s, data_off_s};

    // Read words come straight off the array before this edge's write lands,
    // which gives read-before-write when both ports hit the same word.
    // Select the word seen by each port; out-of-range reads return zero
    always_comb begin
        inst_word_s = {DATA_WIDTH{1'b0}};
        data_word_s = {DATA_WIDTH{1'b0}};
        if (inst_ok_s) begin
            inst_word_s = mem_r[inst_idx_s];
        end else begin
            inst_word_s = {DATA_WIDTH{1'b0}};
        end
        if (data_ok_s) begin
            data_word_s = mem_r[data_idx_s];
        end else begin
            data_word_s = {DATA_WIDTH{1'b0}};
        end
    end

    // ------------------------------------------------------------------
    // Word array: not reset, so contents survive rst. Contents start at
    // all-zero.
    // ------------------------------------------------------------------
    // Byte-lane writes into the array
    always_ff @(posedge clk) begin
        if (data_wr_s && data_ok_s) begin
            for (int b = 0; b < BYTES; b++) begin
                if (data_write_sel[b]) begin
                    mem_r[data_idx_s][8*b +: 8] <= data_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Ready generation
    // ------------------------------------------------------------------
`ifdef SIM_MEM_STALL_EN
    logic [LFSR_WIDTH-1:0] inst_lfsr_r;
    logic [LFSR_WIDTH-1:0] data_lfsr_r;

    // Per-port stall LFSRs; ready_r always equals lfsr_ready() of the current
    // LFSR state, forced low while in reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_lfsr_r  <= STALL_SEED;
            data_lfsr_r  <= ~STALL_SEED;
            inst_ready_r <= 1'b0;
            data_ready_r <= 1'b0;
        end else begin
            inst_lfsr_r  <= lfsr_next(inst_lfsr_r);
            data_lfsr_r  <= lfsr_next(data_lfsr_r);
            inst_ready_r <= lfsr_ready(lfsr_next(inst_lfsr_r));
            data_ready_r <= lfsr_ready(lfsr_next(data_lfsr_r));
        end
    end
`else
    // The seed only matters with stall injection enabled
    logic [LFSR_WIDTH-1:0] unused_stall_s;
    assign unused_stall_s = lfsr_next(STALL_SEED);

    // Ready is low in reset and constantly high afterwards
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_ready_r <= 1'b0;
            data_ready_r <= 1'b0;
        end else begin
            inst_ready_r <= 1'b1;
            data_ready_r <= 1'b1;
        end
    end
`endif

    assign inst_ready = inst_ready_r;
    assign data_ready = data_ready_r;

    // ------------------------------------------------------------------
    // Sticky range error; only reset clears it
    // ------------------------------------------------------------------
    // Set on any accepted access outside the window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_err_r <= 1'b0;
        end else if ((inst_acc_s && !inst_ok_s) || (data_acc_s && !data_ok_s)) begin
            addr_err_r <= 1'b1;
        end else begin
            addr_err_r <= addr_err_r;
        end
    end

    assign addr_err = addr_err_r;

    // ------------------------------------------------------------------
    // Read response pipes, one per port
    // ------------------------------------------------------------------
    sim_mem_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (LAT)
    ) u_inst_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inst_acc_s),
        .in_data   (inst_word_s),
        .out_valid (inst_rvalid),
        .out_data  (inst_rdata)
    );

    sim_mem_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (LAT)
    ) u_data_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (data_rd_s),
        .in_data   (data_word_s),
        .out_valid (data_rvalid),
        .out_data  (data_rdata)
    );

endmodule

// File: tb/tb_sim_mem_model.sv
// ----------------------------------------------------------------------------
// tb_sim_mem_model
//   Scoreboard bench for sim_mem_model. A driver issues requests (held until
//   accepted) and pushes the expected response, computed from a word-indexed
//   associative-array model, into a per-port queue. A monitor pops and
//   compares on every rvalid pulse, including the response cycle.
// ----------------------------------------------------------------------------
module tb_sim_mem_model;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DL    = 8;
    localparam int          RL    = 3;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          WORDS = 1 << DL;
    localparam int          SPAN  = 4 * WORDS;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          inst_en = 1'b0;
    logic [AW-1:0] inst_addr = '0;
    logic          inst_ready;
    logic [DW-1:0] inst_rdata;
    logic          inst_rvalid;
    logic          data_en = 1'b0;
    logic [3:0]    data_write_sel = '0;
    logic [AW-1:0] data_addr = '0;
    logic [DW-1:0] data_wdata = '0;
    logic          data_ready;
    logic [DW-1:0] data_rdata;
    logic          data_rvalid;
    logic          addr_err;

    sim_mem_model #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .DEPTH_LOG2   (DL),
        .BASE_ADDR    (BASE),
        .READ_LATENCY (RL)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_en        (inst_en),
        .inst_addr      (inst_addr),
        .inst_ready     (inst_ready),
        .inst_rdata     (inst_rdata),
        .inst_rvalid    (inst_rvalid),
        .data_en        (data_en),
        .data_write_sel (data_write_sel),
        .data_addr      (data_addr),
        .data_wdata     (data_wdata),
        .data_ready     (data_ready),
        .data_rdata     (data_rdata),
        .data_rvalid    (data_rvalid),
        .addr_err       (addr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        inst_q[$];
    exp_t        data_q[$];
    bit   [31:0] mem_m [int];
    bit          exp_err = 1'b0;

    // pending requests, held until accepted
    bit          ip = 1'b0;
    logic [31:0] ia = '0;
    bit          dp = 1'b0;
    logic [3:0]  ds = '0;
    logic [31:0] da = '0;
    logic [31:0] dw = '0;

    bit stat_on = 1'b0;
    int rdy_hi  = 0;
    int rdy_tot = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit in_rng(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (la >= longint'(BASE)) && (la < longint'(BASE) + longint'(SPAN));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (!in_rng(a)) return 32'h0;
        if (mem_m.exists(widx(a))) return mem_m[widx(a)];
        return 32'h0;
    endfunction

    task automatic model_wr(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] word;
        if (in_rng(a)) begin
            word = model_rd(a);
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) word[8*b +: 8] = w[8*b +: 8];
            end
            mem_m[widx(a)] = word;
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (inst_rvalid !== 1'b0) begin
                    if (inst_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL inst_spurious: rvalid=%b with no outstanding read (cycle %0d)", inst_rvalid, cyc);
                    end else begin
                        e = inst_q.pop_front();
                        chk("inst_rdata", inst_rdata, e.data);
                        chk("inst_timing", cyc, e.due);
                    end
                end
                if (data_rvalid !== 1'b0) begin
                    if (data_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL data_spurious: rvalid=%b with no outstanding read (cycle %0d)", data_rvalid, cyc);
                    end else begin
                        e = data_q.pop_front();
                        chk("data_rdata", data_rdata, e.data);
                        chk("data_timing", cyc, e.due);
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    // One cycle, called at a falling edge; returns at the next falling edge
    task automatic tick();
        bit fire_i, fire_d;
        chk("addr_err", {31'b0, addr_err}, {31'b0, exp_err});
        inst_en        = ip;
        inst_addr      = ia;
        data_en        = dp;
        data_write_sel = ds;
        data_addr      = da;
        data_wdata     = dw;
        if (stat_on) begin
            rdy_tot += 2;
            rdy_hi  += int'(inst_ready) + int'(data_ready);
        end
        fire_i = ip && (inst_ready === 1'b1);
        fire_d = dp && (data_ready === 1'b1);
        // accept edge is cyc+1, response seen RL-1 edges after that
        if (fire_i) begin
            inst_q.push_back('{data: model_rd(ia), due: cyc + RL});
            if (!in_rng(ia)) exp_err = 1'b1;
        end
        if (fire_d) begin
            if (ds == 4'h0) data_q.push_back('{data: model_rd(da), due: cyc + RL});
            else            model_wr(ds, da, dw);
            if (!in_rng(da)) exp_err = 1'b1;
        end
        @(negedge clk);
        if (fire_i) ip = 1'b0;
        if (fire_d) dp = 1'b0;
    endtask

    task automatic drain_pending();
        int n = 0;
        while ((ip || dp) && n < 64) begin
            tick();
            n++;
        end
        checks++;
        if (ip || dp) begin
            errors++;
            $display("FAIL accept_timeout: pending inst=%0b data=%0b after %0d cycles", ip, dp, n);
            ip = 1'b0;
            dp = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd_i(input logic [31:0] a);
        ip = 1'b1; ia = a;
        drain_pending();
    endtask

    task automatic rd_d(input logic [31:0] a);
        dp = 1'b1; ds = 4'h0; da = a;
        drain_pending();
    endtask

    task automatic wr_d(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] w);
        dp = 1'b1; ds = sel; da = a; dw = w;
        drain_pending();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_inst_rvalid"}, {31'b0, inst_rvalid}, 32'h0);
        chk({tag, "_data_rvalid"}, {31'b0, data_rvalid}, 32'h0);
        chk({tag, "_inst_rdata"}, inst_rdata, 32'h0);
        chk({tag, "_data_rdata"}, data_rdata, 32'h0);
        chk({tag, "_addr_err"}, {31'b0, addr_err}, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 15));
        case (r)
            0:       return BASE + SPAN + 4 * $urandom_range(0, 7);
            1:       return BASE - 4 - 4 * $urandom_range(0, 7);
            2:       return BASE + SPAN - 4;
            3:       return BASE + $urandom_range(0, SPAN - 1);
            default: return BASE + 4 * $urandom_range(0, 31);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_req;
        int budget;

        // reset state
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        chk("reset_inst_ready", {31'b0, inst_ready}, 32'h0);
        chk("reset_data_ready", {31'b0, data_ready}, 32'h0);
        rst = 1'b1;
        idle(2);

        // first instruction fetch
        wr_d(4'hF, BASE, 32'h3C01_0001);
        rd_i(BASE);

        // byte-lane merge, plus unaligned address hitting the same word
        wr_d(4'hF, BASE + 32'h10, 32'h1122_3344);
        wr_d(4'b0101, BASE + 32'h10, 32'hAABB_CCDD);
        rd_d(BASE + 32'h10);
        rd_d(BASE + 32'h13);

        // back-to-back pipelined reads
        rd_i(BASE);
        rd_i(BASE + 32'h4);
        rd_i(BASE + 32'h8);

        // same-edge write and instruction read of one word
        ip = 1'b1; ia = BASE + 32'h20;
        dp = 1'b1; ds = 4'hF; da = BASE + 32'h20; dw = 32'hDEAD_BEEF;
        drain_pending();
        rd_i(BASE + 32'h20);
        idle(RL + 1);

        // out-of-range accesses: zero data, sticky error, dropped write
        rd_d(BASE + SPAN);
        rd_i(BASE - 32'h4);
        wr_d(4'hF, BASE + SPAN, 32'h5555_AAAA);
        rd_d(BASE);
        rd_i(BASE + SPAN - 4);
        idle(RL + 2);

        // reset with reads in flight
        rd_d(BASE + 32'h10);
        rd_i(BASE + 32'h20);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        inst_q.delete();
        data_q.delete();
        exp_err = 1'b0;
        inst_en = 1'b0;
        data_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        rd_i(BASE + 32'h20);
        rd_d(BASE + 32'h10);
        rd_i(BASE);
        idle(RL + 1);

        // randomized traffic with both ports concurrently
        stat_on = 1'b1;
        n_req   = 0;
        budget  = 0;
        while (n_req < 1000 && budget < 20000) begin
            if (!ip && $urandom_range(0, 3) != 0 && n_req < 1000) begin
                ip = 1'b1;
                ia = rand_addr();
                n_req++;
            end
            if (!dp && $urandom_range(0, 3) != 0 && n_req < 1000) begin
                dp = 1'b1;
                da = rand_addr();
                dw = $urandom();
                ds = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                n_req++;
            end
            tick();
            budget++;
        end
        drain_pending();
        stat_on = 1'b0;
        idle(RL + 2);

        chk("inst_outstanding", inst_q.size(), 32'h0);
        chk("data_outstanding", data_q.size(), 32'h0);
        chk("random_req_count", n_req, 32'd1000);

`ifdef SIM_MEM_STALL_EN
        checks++;
        if (rdy_hi * 100 < rdy_tot * 70 || rdy_hi * 100 > rdy_tot * 80) begin
            errors++;
            $display("FAIL ready_duty: high %0d of %0d samples, required 70-80%%", rdy_hi, rdy_tot);
        end
`else
        chk("ready_always_high", rdy_hi, rdy_tot);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
